// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Control bundle below is what the top drives onto the segment registers.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [1:0] WD_SEL_MEM = 2'b01;
    localparam logic [1:0] PC_SEL_SEQ = 2'b00;

    typedef struct packed {
        logic dm_req;
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic stall_mem_wb;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_ex_mem;
        logic flush_mem_wb;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and EX redirect detection.
// x0 is never a real destination, so it never creates a hazard.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rf_ra0,
    input  logic [4:0] id_rf_ra1,
    input  logic       id_rf_re0,
    input  logic       id_rf_re1,
    input  logic [4:0] ex_rf_wa,
    input  logic       ex_rf_we,
    input  logic [1:0] ex_rf_wd_sel,
    input  logic [1:0] ex_pc_sel,
    output logic       load_use,
    output logic       redirect
);

    logic ex_load;
    logic hit0;
    logic hit1;

    always_comb begin
        ex_load  = ex_rf_we && (ex_rf_wd_sel == WD_SEL_MEM)
                   && (ex_rf_wa != 5'd0);
        hit0     = id_rf_re0 && (id_rf_ra0 == ex_rf_wa);
        hit1     = id_rf_re1 && (id_rf_ra1 == ex_rf_wa);
        load_use = ex_load && (hit0 || hit1);
        redirect = (ex_pc_sel != PC_SEL_SEQ);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with data-memory handshake FSM,
// memory timeout error and stall/flush performance counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       id_rf_ra0,
    input  logic [4:0]       id_rf_ra1,
    input  logic             id_rf_re0,
    input  logic             id_rf_re1,
    input  logic [4:0]       ex_rf_wa,
    input  logic             ex_rf_we,
    input  logic [1:0]       ex_rf_wd_sel,
    input  logic [1:0]       ex_pc_sel,
    input  logic             mem_access,
    input  logic             dm_ack,
    output logic             dm_req,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             stall_mem_wb,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [TW-1:0]    wcnt_q;
    logic [TW-1:0]    wcnt_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cs_q;
    logic [CNT_W-1:0] cs_d;
    logic [CNT_W-1:0] cf_q;
    logic [CNT_W-1:0] cf_d;

    logic  load_use;
    logic  redirect;
    logic  freeze;
    ctrl_t ctrl;
    ctrl_t ctrl_o;

    hazard_detect u_hazard_detect (
        .id_rf_ra0    (id_rf_ra0),
        .id_rf_ra1    (id_rf_ra1),
        .id_rf_re0    (id_rf_re0),
        .id_rf_re1    (id_rf_re1),
        .ex_rf_wa     (ex_rf_wa),
        .ex_rf_we     (ex_rf_we),
        .ex_rf_wd_sel (ex_rf_wd_sel),
        .ex_pc_sel    (ex_pc_sel),
        .load_use     (load_use),
        .redirect     (redirect)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            cs_q    <= '0;
            cf_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            cs_q    <= cs_d;
            cf_q    <= cf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (mem_access && !dm_ack) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (dm_ack) begin
                    state_d = RUN;
                end else if (wcnt_q == TMO_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Freeze wins; redirect and load-use simply re-present once it lifts.
    always_comb begin
        ctrl   = '0;
        freeze = 1'b0;
        unique case (state_q)
            RUN: begin
                ctrl.dm_req = mem_access;
                freeze      = mem_access && !dm_ack;
            end
            WAIT: begin
                ctrl.dm_req = 1'b1;
                freeze      = !dm_ack;
            end
            ERR: begin
                ctrl.dm_req = 1'b0;
                freeze      = 1'b1;
            end
            default: begin
                freeze = 1'b0;
            end
        endcase
        if (freeze) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.stall_id_ex  = 1'b1;
            ctrl.stall_ex_mem = 1'b1;
            ctrl.flush_mem_wb = 1'b1;
        end else if (redirect) begin
            ctrl.flush_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end else if (load_use) begin
            ctrl.stall_pc     = 1'b1;
            ctrl.stall_if_id  = 1'b1;
            ctrl.flush_id_ex  = 1'b1;
        end
    end

    assign ctrl_o = rstn ? ctrl : '0;

    always_comb begin
        cs_d = cs_q + CNT_W'(ctrl_o.stall_pc);
        cf_d = cf_q + CNT_W'(ctrl_o.flush_if_id);
    end

    assign dm_req       = ctrl_o.dm_req;
    assign stall_pc     = ctrl_o.stall_pc;
    assign stall_if_id  = ctrl_o.stall_if_id;
    assign stall_id_ex  = ctrl_o.stall_id_ex;
    assign stall_ex_mem = ctrl_o.stall_ex_mem;
    assign stall_mem_wb = ctrl_o.stall_mem_wb;
    assign flush_if_id  = ctrl_o.flush_if_id;
    assign flush_id_ex  = ctrl_o.flush_id_ex;
    assign flush_ex_mem = ctrl_o.flush_ex_mem;
    assign flush_mem_wb = ctrl_o.flush_mem_wb;
    assign busy         = rstn && (state_q != RUN);
    assign err          = err_q;
    assign cnt_stall    = cs_q;
    assign cnt_flush    = cf_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic [4:0] ra0;
        logic       re0;
        logic [4:0] ra1;
        logic       re1;
        logic [4:0] wa;
        logic       we;
        logic [1:0] wds;
        logic [1:0] pcs;
        logic       ma;
        logic       ack;
    } stim_t;

    typedef struct packed {
        logic [11:0]   c;
        logic [CW-1:0] cs;
        logic [CW-1:0] cf;
    } exp_t;

    // {dm_req, stall pc/ifid/idex/exmem/memwb, flush ifid/idex/exmem/memwb, busy, err}
    localparam logic [11:0] C_IDLE  = 12'b0_00000_0000_00;
    localparam logic [11:0] C_LU    = 12'b0_11000_0100_00;
    localparam logic [11:0] C_RD    = 12'b0_00000_1100_00;
    localparam logic [11:0] C_REQ   = 12'b1_00000_0000_00;
    localparam logic [11:0] C_FRZR  = 12'b1_11110_0001_00;
    localparam logic [11:0] C_FRZW  = 12'b1_11110_0001_10;
    localparam logic [11:0] C_ACKW  = 12'b1_00000_0000_10;
    localparam logic [11:0] C_ACKRD = 12'b1_00000_1100_10;
    localparam logic [11:0] C_ERR   = 12'b0_11110_0001_11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [4:0]    id_rf_ra0 = '0;
    logic [4:0]    id_rf_ra1 = '0;
    logic          id_rf_re0 = 1'b0;
    logic          id_rf_re1 = 1'b0;
    logic [4:0]    ex_rf_wa = '0;
    logic          ex_rf_we = 1'b0;
    logic [1:0]    ex_rf_wd_sel = '0;
    logic [1:0]    ex_pc_sel = '0;
    logic          mem_access = 1'b0;
    logic          dm_ack = 1'b0;
    logic          dm_req;
    logic          stall_pc, stall_if_id, stall_id_ex;
    logic          stall_ex_mem, stall_mem_wb;
    logic          flush_if_id, flush_id_ex;
    logic          flush_ex_mem, flush_mem_wb;
    logic          busy, err;
    logic [CW-1:0] cnt_stall, cnt_flush;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [CW-1:0] exp_cs;
    logic [CW-1:0] exp_cf;

    pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .id_rf_ra0(id_rf_ra0), .id_rf_ra1(id_rf_ra1),
        .id_rf_re0(id_rf_re0), .id_rf_re1(id_rf_re1),
        .ex_rf_wa(ex_rf_wa), .ex_rf_we(ex_rf_we),
        .ex_rf_wd_sel(ex_rf_wd_sel), .ex_pc_sel(ex_pc_sel),
        .mem_access(mem_access), .dm_ack(dm_ack), .dm_req(dm_req),
        .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
        .stall_mem_wb(stall_mem_wb), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .flush_mem_wb(flush_mem_wb), .busy(busy), .err(err),
        .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic [4:0] ra0, input logic re0,
                                 input logic [4:0] ra1, input logic re1,
                                 input logic [4:0] wa, input logic we,
                                 input logic [1:0] wds, input logic [1:0] pcs,
                                 input logic ma, input logic ack);
        return '{ra0, re0, ra1, re1, wa, we, wds, pcs, ma, ack};
    endfunction

    function automatic exp_t observed();
        return '{{dm_req, stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                  stall_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
                  flush_mem_wb, busy, err}, cnt_stall, cnt_flush};
    endfunction

    task automatic drive(input stim_t s);
        id_rf_ra0 = s.ra0; id_rf_re0 = s.re0;
        id_rf_ra1 = s.ra1; id_rf_re1 = s.re1;
        ex_rf_wa = s.wa; ex_rf_we = s.we;
        ex_rf_wd_sel = s.wds; ex_pc_sel = s.pcs;
        mem_access = s.ma; dm_ack = s.ack;
    endtask

    // Expected counters are the totals before this cycle's edge.
    task automatic push_exp(input logic [11:0] c);
        sb.push_back('{c, exp_cs, exp_cf});
        if (c[10]) exp_cs = exp_cs + 1'b1;
        if (c[5])  exp_cf = exp_cf + 1'b1;
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_cs = '0;
        exp_cf = '0;
        sb.delete();
    endtask

    stim_t S_IDLE, S_LU, S_LU1, S_NOLD, S_RDLU, S_X0, S_NORE;
    stim_t S_MEM, S_MACK, S_MLU, S_MLURD, S_ACKRD;

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0;
        drive(mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b01, 1, 0));
        #1;
        e = '0;
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL reset got=%h want=%h", observed(), e);
        end
        apply_reset();
    endtask

    task automatic test_load_use();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_LU, S_IDLE, S_LU1, S_NOLD, S_IDLE};
        cq = '{C_LU, C_IDLE, C_LU, C_IDLE, C_IDLE};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL load_use[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_RDLU, S_IDLE};
        cq = '{C_RD, C_IDLE};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL redirect[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_x0();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_X0, S_NORE, S_IDLE};
        cq = '{C_IDLE, C_IDLE, C_IDLE};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL x0[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_MEM, S_MEM, S_MEM, S_MACK, S_IDLE, S_MACK, S_IDLE};
        cq = '{C_FRZR, C_FRZW, C_FRZW, C_ACKW, C_IDLE, C_REQ, C_IDLE};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL mem_wait[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_MLU, S_MLURD, S_ACKRD, S_LU, S_IDLE};
        cq = '{C_FRZR, C_FRZW, C_ACKRD, C_LU, C_IDLE};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_in_wait();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq = '{S_MEM, S_MEM};
        cq = '{C_FRZR, C_FRZW};
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL rst_wait[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        e = '0;
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL rst_wait_async got=%h want=%h", observed(), e);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        drive(S_IDLE);
        @(negedge clk);
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL rst_wait_run got=%h want=%h", observed(), e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        stim_t sq[$];
        logic [11:0] cq[$];
        exp_t e;
        apply_reset();
        sq.push_back(S_MEM); cq.push_back(C_FRZR);
        for (int k = 0; k < 8; k++) begin
            sq.push_back(S_MEM); cq.push_back(C_FRZW);
        end
        sq.push_back(S_MEM);  cq.push_back(C_ERR);
        sq.push_back(S_MACK); cq.push_back(C_ERR);
        sq.push_back(S_IDLE); cq.push_back(C_ERR);
        foreach (sq[i]) begin
            drive(sq[i]); push_exp(cq[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL timeout[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        e = '0;
        checks++;
        if (observed() !== e) begin
            failures++;
            $display("FAIL timeout_rst got=%h want=%h", observed(), e);
        end
        apply_reset();
    endtask

    task automatic test_cnt_wrap();
        exp_t e;
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            drive(S_RDLU); push_exp(C_RD);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (observed() !== e) begin
                failures++;
                $display("FAIL cnt_wrap[%0d] got=%h want=%h", i, observed(), e);
            end
            @(posedge clk); #1;
        end
        drive(S_IDLE);
        @(negedge clk);
        checks++;
        if (cnt_flush !== 4'd1) begin
            failures++;
            $display("FAIL cnt_wrap_final got=%0d want=1", cnt_flush);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        S_IDLE  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        S_LU    = mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b00, 0, 0);
        S_LU1   = mk(3, 0, 7, 1, 7, 1, 2'b01, 2'b00, 0, 0);
        S_NOLD  = mk(5, 1, 0, 0, 5, 1, 2'b00, 2'b00, 0, 0);
        S_RDLU  = mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b01, 0, 0);
        S_X0    = mk(0, 1, 0, 1, 0, 1, 2'b01, 2'b00, 0, 0);
        S_NORE  = mk(9, 0, 9, 0, 9, 1, 2'b01, 2'b00, 0, 0);
        S_MEM   = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        S_MACK  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        S_MLU   = mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b00, 1, 0);
        S_MLURD = mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b01, 1, 0);
        S_ACKRD = mk(5, 1, 0, 0, 5, 1, 2'b01, 2'b01, 1, 1);
        exp_cs = '0;
        exp_cf = '0;
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_x0();
        test_mem_wait();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        test_cnt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
